cpu_checker: RTL and testbench

- Byte-serial parser for CPU trace lines. One ASCII character is consumed per clock.
- On a well-formed line it reports the line type: register write or memory write.
- It also checks semantic errors: time vs. clock frequency, PC range/alignment, address range/alignment, and register number.
- It sits beside the simulator log stream as a self-checking monitor.

---
 rtl/cpu_checker_pkg.sv | 50 +++++
 rtl/cpu_checker_char_class.sv | 19 +
 rtl/cpu_checker.sv | 185 ++++++++++++++++++
 tb/tb_cpu_checker.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cpu_checker_pkg.sv
// Shared types and constants for the CPU trace-line checker.
// Holds the parser state encoding, ASCII delimiters and the legal address windows.
package cpu_checker_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StTime,
    StPc,
    StColonSp,
    StRegSp,
    StGrf,
    StAddr,
    StPreLt,
    StEq,
    StPostEq,
    StData,
    StHash,
    StDoneReg,
    StDoneMem,
    StErr
  } state_e;

  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_REG  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  localparam logic [7:0] CHAR_CARET  = 8'h5e;
  localparam logic [7:0] CHAR_AT     = 8'h40;
  localparam logic [7:0] CHAR_COLON  = 8'h3a;
  localparam logic [7:0] CHAR_DOLLAR = 8'h24;
  localparam logic [7:0] CHAR_STAR   = 8'h2a;
  localparam logic [7:0] CHAR_LT     = 8'h3c;
  localparam logic [7:0] CHAR_EQ     = 8'h3d;
  localparam logic [7:0] CHAR_HASH   = 8'h23;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam logic [7:0] CHAR_NUL    = 8'h00;

  localparam logic [31:0] PC_LO   = 32'h0000_3000;
  localparam logic [31:0] PC_HI   = 32'h0000_4fff;
  localparam logic [31:0] ADDR_HI = 32'h0000_2fff;
  localparam logic [13:0] GRF_MAX = 14'd31;

  // freq is a power of two, so freq/2 - 1 masks the bits that must be zero.
  function automatic logic time_misaligned(logic [13:0] t, logic [15:0] f);
    logic [15:0] mask;
    mask = (f >> 1) - 16'd1;
    return ({2'b00, t} & mask) != 16'd0;
  endfunction

endpackage

// File: rtl/cpu_checker_char_class.sv
// Combinational character classifier: decimal / lowercase-hex detection and nibble value.
module cpu_checker_char_class (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic is_lower_hex;

  always_comb begin
    is_dec       = (char >= 8'h30) && (char <= 8'h39);
    is_lower_hex = (char >= 8'h61) && (char <= 8'h66);
    is_hex       = is_dec || is_lower_hex;
    // '0'..'9' carry their value in the low nibble; 'a'..'f' sit at 1..6, so add 9.
    nibble       = is_dec ? char[3:0] : (char[3:0] + 4'd9);
  end

endmodule

// File: rtl/cpu_checker.sv
// Byte-serial CPU trace-line parser: reports line type for one cycle after a valid '#'
// together with time/pc/addr/grf semantic error flags.
module cpu_checker
  import cpu_checker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [15:0] freq,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code
);

  state_e      state_q;
  logic [13:0] time_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [13:0] grf_q;
  logic [3:0]  cnt_q;
  logic        mem_q;

  logic        is_dec;
  logic        is_hex;
  logic [3:0]  nibble;
  logic        is_space;
  logic        time_err;
  logic        pc_err;
  logic        addr_err;
  logic        grf_err;

  cpu_checker_char_class u_char_class (
    .char   (char),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  always_comb begin
    is_space = (char == CHAR_SPACE);
    time_err = time_misaligned(time_q, freq);
    pc_err   = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);
    addr_err = (addr_q[1:0] != 2'b00) || (addr_q > ADDR_HI);
    grf_err  = (grf_q > GRF_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      time_q      <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      grf_q       <= '0;
      cnt_q       <= '0;
      mem_q       <= 1'b0;
      format_type <= FMT_NONE;
      error_code  <= '0;
    end else begin
      format_type <= FMT_NONE;
      error_code  <= '0;
      if (char == CHAR_CARET) begin
        state_q <= StTime;
        time_q  <= '0;
        pc_q    <= '0;
        addr_q  <= '0;
        grf_q   <= '0;
        cnt_q   <= '0;
        mem_q   <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (char != CHAR_NUL) state_q <= StErr;
          end
          StTime: begin
            if (is_dec && cnt_q < 4'd4) begin
              time_q <= time_q * 14'd10 + {10'd0, nibble};
              cnt_q  <= cnt_q + 4'd1;
            end else if (char == CHAR_AT && cnt_q != 4'd0) begin
              state_q <= StPc;
              cnt_q   <= '0;
            end else begin
              state_q <= StErr;
            end
          end
          StPc: begin
            if (is_hex && cnt_q < 4'd8) begin
              pc_q  <= {pc_q[27:0], nibble};
              cnt_q <= cnt_q + 4'd1;
            end else if (char == CHAR_COLON && cnt_q == 4'd8) begin
              state_q <= StColonSp;
            end else begin
              state_q <= StErr;
            end
          end
          StColonSp: begin
            if (char == CHAR_DOLLAR) begin
              state_q <= StRegSp;
            end else if (char == CHAR_STAR) begin
              state_q <= StAddr;
              mem_q   <= 1'b1;
              cnt_q   <= '0;
            end else if (!is_space) begin
              state_q <= StErr;
            end
          end
          StRegSp: begin
            if (is_dec) begin
              state_q <= StGrf;
              grf_q   <= {10'd0, nibble};
              cnt_q   <= 4'd1;
            end else if (!is_space) begin
              state_q <= StErr;
            end
          end
          StGrf: begin
            if (is_dec && cnt_q < 4'd4) begin
              grf_q <= grf_q * 14'd10 + {10'd0, nibble};
              cnt_q <= cnt_q + 4'd1;
            end else if (is_space) begin
              state_q <= StPreLt;
            end else if (char == CHAR_LT) begin
              state_q <= StEq;
            end else begin
              state_q <= StErr;
            end
          end
          StAddr: begin
            if (is_hex && cnt_q < 4'd8) begin
              addr_q <= {addr_q[27:0], nibble};
              cnt_q  <= cnt_q + 4'd1;
            end else if (is_space && cnt_q == 4'd8) begin
              state_q <= StPreLt;
            end else if (char == CHAR_LT && cnt_q == 4'd8) begin
              state_q <= StEq;
            end else begin
              state_q <= StErr;
            end
          end
          StPreLt: begin
            if (char == CHAR_LT) state_q <= StEq;
            else if (!is_space) state_q <= StErr;
          end
          StEq: begin
            state_q <= (char == CHAR_EQ) ? StPostEq : StErr;
          end
          StPostEq: begin
            if (is_hex) begin
              state_q <= StData;
              cnt_q   <= 4'd1;
            end else if (!is_space) begin
              state_q <= StErr;
            end
          end
          StData: begin
            // Eighth data digit moves on to wait for the closing '#'.
            if (is_hex) begin
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) state_q <= StHash;
            end else begin
              state_q <= StErr;
            end
          end
          StHash: begin
            if (char == CHAR_HASH) begin
              state_q     <= mem_q ? StDoneMem : StDoneReg;
              format_type <= mem_q ? FMT_MEM : FMT_REG;
              error_code  <= {grf_err & ~mem_q, addr_err & mem_q, pc_err, time_err};
            end else begin
              state_q <= StErr;
            end
          end
          StDoneReg, StDoneMem: begin
            state_q <= StIdle;
          end
          StErr: begin
            state_q <= StErr;
          end
          default: begin
            state_q <= StErr;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_checker.sv
// Directed bench for cpu_checker: streams trace lines and compares the one-cycle result pulse.
module tb_cpu_checker;

  logic        clk;
  logic        reset;
  logic [7:0]  char;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;

  int n_checks;
  int n_errors;
  int pulses;
  int stray;

  cpu_checker dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .freq        (freq),
    .format_type (format_type),
    .error_code  (error_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (format_type != 2'd0) pulses++;
    if (format_type == 2'd0 && error_code != 4'd0) stray++;
  endtask

  // Drive one character per cycle on the falling edge, sampling outputs first.
  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      sample();
      char = s[i];
    end
  endtask

  task automatic run_line(input string tag, input string s, input logic [15:0] f,
                          input logic [1:0] exp_fmt, input logic [3:0] exp_err);
    logic [1:0] fmt_end;
    logic [3:0] err_end;
    freq   = f;
    pulses = 0;
    stray  = 0;
    feed(s);
    @(negedge clk);
    sample();
    fmt_end = format_type;
    err_end = error_code;
    char = 8'h00;
    @(negedge clk);
    sample();
    check({tag, " fmt"}, 32'(fmt_end), 32'(exp_fmt));
    check({tag, " err"}, 32'(err_end), 32'(exp_err));
    check({tag, " pulses"}, pulses, (exp_fmt != 2'd0) ? 1 : 0);
    check({tag, " stray_err"}, stray, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    char  = 8'h00;
    freq  = 16'd4;
    #12;
    check("reset fmt", 32'(format_type), 0);
    check("reset err", 32'(error_code), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle nul", 32'({format_type, error_code}), 0);
    end

    run_line("reg_ok", "^10@00003000: $ 1 <= 0000000f#", 16'd4, 2'd1, 4'b0000);
    run_line("mem_errs", "^3@00003002:*00003000<=12345678#", 16'd8, 2'd2, 4'b0111);
    run_line("reg_pc_grf", "^1@00005000: $ 40 <= 00000000#", 16'd2, 2'd1, 4'b1010);
    run_line("mem_edge_ok", "^0008@00004ffc:*00002ffc <= abcdef01#", 16'd16, 2'd2, 4'b0000);
    run_line("reg_lead0", "^4@00002ffc: $ 0032 <= 00000000#", 16'd8, 2'd1, 4'b1010);

    run_line("time5", "^12345@00003000: $ 1 <= 00000000#", 16'd4, 2'd0, 4'b0000);
    run_line("nonhex", "^1@0000300G: $ 1 <= 00000000#", 16'd4, 2'd0, 4'b0000);
    run_line("upper", "^1@0000300A: $ 1 <= 00000000#", 16'd4, 2'd0, 4'b0000);
    run_line("pc9", "^1@000030000: $ 1 <= 00000000#", 16'd4, 2'd0, 4'b0000);
    run_line("no_eq", "^1@00003000:$1<00000000#", 16'd4, 2'd0, 4'b0000);
    run_line("data9", "^1@00003000:$1<=000000000#", 16'd4, 2'd0, 4'b0000);

    // time 2 is a multiple of freq/2 = 2 but not of 4.
    run_line("restart_f4", "^1@00^2@00003004:$0<=00000000#", 16'd4, 2'd1, 4'b0000);
    run_line("restart_f8", "^1@00^2@00003004:$0<=00000000#", 16'd8, 2'd1, 4'b0001);

    // Reset in the middle of the data field: outputs clear, remainder of line is rejected.
    freq   = 16'd4;
    pulses = 0;
    stray  = 0;
    feed("^10@00003000: $ 1 <= 0000");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_data fmt", 32'(format_type), 0);
    check("rst_data err", 32'(error_code), 0);
    @(negedge clk);
    char  = 8'h00;
    reset = 1'b1;
    feed("0000#");
    @(negedge clk);
    sample();
    char = 8'h00;
    @(negedge clk);
    sample();
    check("rst_data tail pulses", pulses, 0);

    // Reset while the result pulse is up must clear it before the next clock edge.
    freq = 16'd2;
    feed("^1@00005000: $ 40 <= 00000000#");
    @(posedge clk);
    #1;
    check("pulse before rst fmt", 32'(format_type), 1);
    check("pulse before rst err", 32'(error_code), 32'b1010);
    reset = 1'b0;
    #1;
    check("async rst fmt", 32'(format_type), 0);
    check("async rst err", 32'(error_code), 0);
    @(negedge clk);
    char  = 8'h00;
    reset = 1'b1;
    run_line("after_rst", "^10@00003000: $ 1 <= 0000000f#", 16'd4, 2'd1, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
